lcd_hd44780_refresh: RTL and testbench

- Parametrised HD44780 character-LCD controller for the DE2-115 LCD header.
- Runs a timed power-up init sequence, then continuously refreshes the panel from an internal ROWS x COLS character buffer.
- The user logic writes characters into the buffer through a simple synchronous write port and never handles LCD bus timing.
- Replaces free-running, counter-paced LCD demos with correct per-command timing, reset, and arbitrary text.

---
 rtl/lcd_hd44780_refresh_if.sv | 13 +
 rtl/lcd_hd44780_refresh.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_hd44780_refresh.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_refresh_if.sv
// Character-buffer write port for lcd_hd44780_refresh.
// The controller range-checks the full BUF_ADDR value, so the address bus may
// be wider than $clog2(ROWS*COLS) without aliasing onto valid entries.
interface lcd_hd44780_refresh_if #(
  parameter int AW = 5
);
  logic          BUF_WE;
  logic [AW-1:0] BUF_ADDR;
  logic [7:0]    BUF_DATA;

  modport master (output BUF_WE, BUF_ADDR, BUF_DATA);
  modport slave  (input  BUF_WE, BUF_ADDR, BUF_DATA);
endinterface

// File: rtl/lcd_hd44780_refresh.sv
// HD44780 character-LCD controller: timed power-up init, then continuous
// refresh of the panel from an internal ROWS x COLS character buffer.
module lcd_hd44780_refresh #(
  parameter int CLK_HZ    = 50000000,
  parameter int COLS      = 16,
  parameter int ROWS      = 2,
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 12,
  parameter int PWR_US    = 15000,
  parameter int INIT_US   = 4100,
  parameter int CMD_US    = 40,
  parameter int CLEAR_US  = 1640
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  lcd_hd44780_refresh_if.slave wr,
  output logic       READY,
  output logic       FRAME_DONE,
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  localparam int unsigned CYC_US = CLK_HZ / 1000000;
  localparam int unsigned DEPTH  = ROWS * COLS;
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW     = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [31:0] PWR_LEN   = 32'(PWR_US * CYC_US);
  localparam logic [31:0] INIT_LEN  = 32'(INIT_US * CYC_US);
  localparam logic [31:0] CMD_LEN   = 32'(CMD_US * CYC_US);
  localparam logic [31:0] CLEAR_LEN = 32'(CLEAR_US * CYC_US);
  localparam logic [31:0] SETUP_LEN = 32'(SETUP_CYC);
  localparam logic [31:0] EN_LEN    = 32'(EN_CYC);
  localparam logic [7:0]  FS        = (ROWS == 2) ? 8'h38 : 8'h30;

  typedef enum logic [1:0] {PWR_WAIT, INIT, ADDR, CHARS} top_t;
  typedef enum logic [1:0] {SETUP, EN_HI, HOLD} bus_t;

  top_t          top;
  bus_t          bus;
  logic [31:0]   timer;
  logic [31:0]   hold_len;
  logic [2:0]    init_idx;
  logic [2:0]    next_init;
  logic [7:0]    init_byte;
  logic          row;
  logic [CW-1:0] col;

  logic [7:0]    mem [DEPTH];
  logic          wr_ok;
  logic [AW-1:0] wr_idx;
  logic [31:0]   rd_lin;
  logic [AW-1:0] rd_idx;
  logic [7:0]    rd_char;

  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

  assign wr_ok  = 32'(wr.BUF_ADDR) < DEPTH;
  assign wr_idx = AW'(wr.BUF_ADDR);

  // Character buffer: async clear to spaces, one write per cycle.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= 8'h20;
    end else if (wr.BUF_WE && wr_ok) begin
      mem[wr_idx] <= wr.BUF_DATA;
    end
  end

  // Address of the character loaded at the next SETUP (first column after
  // ADDR, else the column after the current one).
  always_comb begin
    rd_lin = 32'(row) * 32'(COLS);
    if (top != ADDR) rd_lin = rd_lin + 32'(col) + 32'd1;
    rd_idx  = AW'(rd_lin);
    rd_char = mem[rd_idx];
  end

  // Next init-sequence byte.
  always_comb begin
    next_init = init_idx + 3'd1;
    case (next_init)
      3'd1, 3'd2: init_byte = FS;
      3'd3:       init_byte = 8'h0C;
      3'd4:       init_byte = 8'h06;
      default:    init_byte = 8'h01;
    endcase
  end

  // Sequencer: power-up wait, then SETUP/EN_HI/HOLD bus cycles per byte.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      top        <= PWR_WAIT;
      bus        <= SETUP;
      timer      <= '0;
      hold_len   <= CMD_LEN;
      init_idx   <= '0;
      row        <= 1'b0;
      col        <= '0;
      LCD_EN     <= 1'b0;
      LCD_RS     <= 1'b0;
      LCD_DATA   <= '0;
      READY      <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      if (top == PWR_WAIT) begin
        if (timer == PWR_LEN - 32'd1) begin
          timer    <= '0;
          top      <= INIT;
          bus      <= SETUP;
          init_idx <= '0;
          LCD_DATA <= FS;
          LCD_RS   <= 1'b0;
          hold_len <= INIT_LEN;
        end else begin
          timer <= timer + 32'd1;
        end
      end else begin
        case (bus)
          SETUP: begin
            if (timer == SETUP_LEN - 32'd1) begin
              timer  <= '0;
              bus    <= EN_HI;
              LCD_EN <= 1'b1;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          EN_HI: begin
            if (timer == EN_LEN - 32'd1) begin
              timer  <= '0;
              bus    <= HOLD;
              LCD_EN <= 1'b0;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          default: begin
            if (timer == hold_len - 32'd1) begin
              timer    <= '0;
              bus      <= SETUP;
              hold_len <= CMD_LEN;
              case (top)
                INIT: begin
                  if (init_idx == 3'd5) begin
                    READY    <= 1'b1;
                    top      <= ADDR;
                    row      <= 1'b0;
                    LCD_DATA <= 8'h80;
                    LCD_RS   <= 1'b0;
                  end else begin
                    init_idx <= next_init;
                    LCD_DATA <= init_byte;
                    LCD_RS   <= 1'b0;
                    if (next_init == 3'd5) hold_len <= CLEAR_LEN;
                  end
                end
                ADDR: begin
                  top      <= CHARS;
                  col      <= '0;
                  LCD_DATA <= rd_char;
                  LCD_RS   <= 1'b1;
                end
                CHARS: begin
                  if (col == CW'(COLS - 1)) begin
                    top    <= ADDR;
                    LCD_RS <= 1'b0;
                    if (row == 1'(ROWS - 1)) begin
                      FRAME_DONE <= 1'b1;
                      row        <= 1'b0;
                      LCD_DATA   <= 8'h80;
                    end else begin
                      row      <= 1'b1;
                      LCD_DATA <= 8'hC0;
                    end
                  end else begin
                    col      <= col + CW'(1);
                    LCD_DATA <= rd_char;
                    LCD_RS   <= 1'b1;
                  end
                end
                default: top <= PWR_WAIT;
              endcase
            end else begin
              timer <= timer + 32'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_refresh.sv
// Self-checking bench for lcd_hd44780_refresh (CYC_US=1, 4x2 panel).
module tb_lcd_hd44780_refresh;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int N     = ROWS * COLS;
  localparam int XACT  = 2 + 3 + 40;        // setup + enable + command wait
  localparam int FRAME = ROWS * (COLS + 1) * XACT;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready, fd, en, rs, rw, lcd_on, blon;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_hd44780_refresh_if #(.AW(4)) wr ();

  lcd_hd44780_refresh #(
    .CLK_HZ(1000000), .COLS(COLS), .ROWS(ROWS), .SETUP_CYC(2), .EN_CYC(3)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .wr(wr),
    .READY(ready), .FRAME_DONE(fd), .LCD_DATA(lcd_data), .LCD_EN(en),
    .LCD_RS(rs), .LCD_RW(rw), .LCD_ON(lcd_on), .LCD_BLON(blon)
  );

  typedef struct {
    logic [7:0] d;
    logic       rs;
    logic       rdy;
    int         c;
  } rise_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         ready_cyc = -1;
  int         exp_ready = 0;
  rise_t      rises[$];
  int         fds[$];
  logic       en_q = 1'b0, ready_q = 1'b0, rs_q = 1'b0;
  logic [7:0] data_q = '0;
  logic [7:0] ref_buf [N];

  // Bus monitor sampled 1 ns after each rising edge; also checks that
  // DATA/RS are frozen while EN is high.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (en === 1'b1 && en_q === 1'b1) begin
      tests++;
      if (lcd_data !== data_q || rs !== rs_q) begin
        fails++;
        $display("FAIL en_stable @%0d: data=%h rs=%b, required %h/%b", cyc, lcd_data, rs, data_q, rs_q);
      end
    end
    if (en === 1'b1 && en_q !== 1'b1) rises.push_back('{d: lcd_data, rs: rs, rdy: ready, c: cyc});
    if (ready === 1'b1 && ready_q !== 1'b1) ready_cyc = cyc;
    if (fd === 1'b1) fds.push_back(cyc);
    en_q = en; ready_q = ready; data_q = lcd_data; rs_q = rs;
  end

  task automatic write_raw(input int addr, input logic [7:0] d);
    @(negedge clk);
    wr.BUF_WE = 1'b1; wr.BUF_ADDR = 4'(addr); wr.BUF_DATA = d;
    @(negedge clk);
    wr.BUF_WE = 1'b0;
  endtask

  task automatic write_buf(input int addr, input logic [7:0] d);
    write_raw(addr, d);
    if (addr < N) ref_buf[addr] = d;
  endtask

  // Wait for the next FRAME_DONE and start collecting a fresh frame.
  task automatic sync_frame(input string tag);
    int n = fds.size();
    for (int i = 0; i < 2 * FRAME && fds.size() <= n; i++) @(negedge clk);
    tests++;
    if (fds.size() <= n) begin
      fails++;
      $display("FAIL %s_sync: no FRAME_DONE within %0d cycles, required one", tag, 2 * FRAME);
    end
    rises.delete();
  endtask

  // Compare the next 10 EN rises against the reference frame.
  task automatic check_frame(input string tag, input int exp_start);
    for (int i = 0; i < 2 * FRAME && rises.size() < 10; i++) @(negedge clk);
    tests++;
    if (rises.size() < 10) begin
      fails++;
      $display("FAIL %s_len: %0d EN rises, required 10", tag, rises.size());
      return;
    end
    for (int i = 0; i < 10; i++) begin
      int r = i / (COLS + 1);
      int k = i % (COLS + 1);
      logic [7:0] ed;
      logic er;
      if (k == 0) begin
        ed = (r == 0) ? 8'h80 : 8'hC0;
        er = 1'b0;
      end else begin
        ed = ref_buf[r * COLS + k - 1];
        er = 1'b1;
      end
      tests++;
      if (rises[i].d !== ed || rises[i].rs !== er) begin
        fails++;
        $display("FAIL %s_byte%0d: data=%h rs=%b, required %h/%b", tag, i, rises[i].d, rises[i].rs, ed, er);
      end
      tests++;
      if (i == 0 && exp_start >= 0 && rises[0].c != exp_start) begin
        fails++;
        $display("FAIL %s_start: cycle %0d, required %0d", tag, rises[0].c, exp_start);
      end else if (i > 0 && rises[i].c - rises[i-1].c != XACT) begin
        fails++;
        $display("FAIL %s_gap%0d: %0d cycles, required %0d", tag, i, rises[i].c - rises[i-1].c, XACT);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if (en !== 1'b0 || rs !== 1'b0 || lcd_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_bus: en=%b rs=%b data=%h, required 0/0/00", en, rs, lcd_data);
    end
    tests++;
    if (ready !== 1'b0 || fd !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: ready=%b frame_done=%b, required 0/0", ready, fd);
    end
    tests++;
    if (rw !== 1'b0 || lcd_on !== 1'b1 || blon !== 1'b1) begin
      fails++;
      $display("FAIL reset_ties: rw=%b on=%b blon=%b, required 0/1/1", rw, lcd_on, blon);
    end
  endtask

  // Releases reset and checks power-up wait, init bytes/spacing and READY.
  task automatic test_init(input string tag);
    logic [7:0] exp_b [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    int gap [6] = '{4100 + 5, 40 + 5, 40 + 5, 40 + 5, 40 + 5, 0};
    int t0, ec;
    rises.delete(); fds.delete(); ready_cyc = -1;
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 25000 && rises.size() < 6; i++) @(negedge clk);
    tests++;
    if (rises.size() < 6) begin
      fails++;
      $display("FAIL %s_count: %0d init EN rises, required 6", tag, rises.size());
      return;
    end
    ec = t0 + 15000 + 2;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (rises[i].d !== exp_b[i] || rises[i].rs !== 1'b0 || rises[i].rdy !== 1'b0) begin
        fails++;
        $display("FAIL %s_byte%0d: data=%h rs=%b ready=%b, required %h/0/0", tag, i, rises[i].d, rises[i].rs, rises[i].rdy, exp_b[i]);
      end
      tests++;
      if (rises[i].c != ec) begin
        fails++;
        $display("FAIL %s_time%0d: EN rise at %0d, required %0d", tag, i, rises[i].c - t0, ec - t0);
      end
      if (i < 5) ec += gap[i];
    end
    exp_ready = ec + 1640 + 3;
    for (int i = 0; i < 3000 && ready_cyc < 0; i++) @(negedge clk);
    tests++;
    if (ready_cyc != exp_ready) begin
      fails++;
      $display("FAIL %s_ready: READY rose at %0d, required %0d", tag, ready_cyc - t0, exp_ready - t0);
    end
    rises.delete(); fds.delete();
  endtask

  task automatic test_default_frame;
    check_frame("default", exp_ready + 2);
    for (int i = 0; i < 4 * FRAME && fds.size() < 3; i++) @(negedge clk);
    tests++;
    if (fds.size() < 3) begin
      fails++;
      $display("FAIL frame_done_count: %0d pulses, required 3", fds.size());
      return;
    end
    tests++;
    if (fds[0] != exp_ready + FRAME) begin
      fails++;
      $display("FAIL frame_done_first: at %0d, required %0d", fds[0], exp_ready + FRAME);
    end
    for (int i = 1; i < 3; i++) begin
      tests++;
      if (fds[i] - fds[i-1] != FRAME) begin
        fails++;
        $display("FAIL frame_done_period%0d: %0d cycles, required %0d", i, fds[i] - fds[i-1], FRAME);
      end
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_hold: ready=%b, required 1", ready);
    end
  endtask

  task automatic test_buffer_write;
    sync_frame("buf_write");
    write_buf(0, 8'h48);
    write_buf(1, 8'h69);
    write_buf(5, 8'h21);
    check_frame("buf_write", -1);
  endtask

  task automatic test_out_of_range;
    sync_frame("oor");
    write_buf(8, 8'h58);
    write_buf(15, 8'h59);
    check_frame("oor_a", -1);
    sync_frame("oor");
    check_frame("oor_b", -1);
  endtask

  task automatic test_write_during_en;
    logic [7:0] v;
    sync_frame("en_write");
    for (int i = 0; i < FRAME && rises.size() < 2; i++) @(negedge clk);
    tests++;
    if (rises.size() < 2 || en !== 1'b1 || rises[1].rs !== 1'b1) begin
      fails++;
      $display("FAIL en_write_pos: rises=%0d en=%b, required char0 EN high", rises.size(), en);
      return;
    end
    v = (ref_buf[0] == 8'h7E) ? 8'h41 : ref_buf[0] + 8'd1;
    write_raw(0, v);
    check_frame("en_write_old", -1);
    ref_buf[0] = v;
    sync_frame("en_write");
    check_frame("en_write_new", -1);
  endtask

  task automatic test_random;
    for (int f = 0; f < 5; f++) begin
      int k;
      sync_frame("rand");
      k = $urandom_range(1, 8);
      for (int j = 0; j < k; j++)
        write_buf($urandom_range(0, 11), 8'($urandom_range(8'h21, 8'h7E)));
      check_frame("rand", -1);
    end
  endtask

  task automatic test_reset_mid_frame;
    sync_frame("mid_reset");
    write_buf(2, 8'h5A);
    for (int i = 0; i < FRAME && rises.size() < 2; i++) @(negedge clk);
    tests++;
    if (rises.size() < 2 || en !== 1'b1 || rises[1].rs !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_pos: rises=%0d en=%b, required char EN high", rises.size(), en);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (en !== 1'b0 || ready !== 1'b0 || rs !== 1'b0 || lcd_data !== 8'h00 || fd !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_out: en=%b ready=%b rs=%b data=%h fd=%b, required 0/0/0/00/0", en, ready, rs, lcd_data, fd);
    end
    for (int i = 0; i < N; i++) ref_buf[i] = 8'h20;
    repeat (3) @(negedge clk);
    test_init("reinit");
    check_frame("after_reset", exp_ready + 2);
  endtask

  initial begin
    wr.BUF_WE = 1'b0; wr.BUF_ADDR = '0; wr.BUF_DATA = '0;
    for (int i = 0; i < N; i++) ref_buf[i] = 8'h20;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_init("init");
    test_default_frame();
    test_buffer_write();
    test_out_of_range();
    test_write_during_en();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
